// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating bubble counter.
// Latency: one cycle from id_* to ex_*; stall is combinational in the same cycle.
// Backpressure: hold freezes every ex_* register, and stall freezes PC and IF/ID upstream;
// flush overrides both.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   id_*                  decoded instruction fields from the ID stage
//   hold, flush           downstream busy / branch-taken kill
//   ex_*                  registered ID/EX contents; ex_rs and ex_rt feed forwarding
//   stall                 freeze PC and IF/ID (combinational)
//   stall_count           number of load-use bubbles inserted, saturating
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc,
    input  logic              id_RegWrite,
    input  logic              id_MemRead,
    input  logic              id_MemWrite,
    input  logic              id_MemtoReg,
    input  logic              id_ALUSrc,
    input  logic [3:0]        id_ALUOp,
    input  logic              hold,
    input  logic              flush,
    output logic              ex_valid,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc,
    output logic              ex_RegWrite,
    output logic              ex_MemRead,
    output logic              ex_MemWrite,
    output logic              ex_MemtoReg,
    output logic              ex_ALUSrc,
    output logic [3:0]        ex_ALUOp,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    typedef struct packed {
        logic              valid;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              alu_src;
        logic [3:0]        alu_op;
    } ex_reg_t;

    ex_reg_t          ex_q;
    ex_reg_t          ex_d;
    ex_reg_t          id_word;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             load_use;

    always_comb begin
        id_word = '{
            valid:      id_valid,
            rs:         id_rs,
            rt:         id_rt,
            rd:         id_rd,
            rs_data:    id_rs_data,
            rt_data:    id_rt_data,
            imm:        id_imm,
            pc:         id_pc,
            reg_write:  id_RegWrite,
            mem_read:   id_MemRead,
            mem_write:  id_MemWrite,
            mem_to_reg: id_MemtoReg,
            alu_src:    id_ALUSrc,
            alu_op:     id_ALUOp
        };
    end

    // A load in EX whose result is read by the instruction in ID cannot be
    // forwarded in time; r0 is hardwired, so it never creates a dependency.
    always_comb begin
        load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & id_valid &
                   ((id_uses_rs & (id_rs == ex_q.rd)) |
                    (id_uses_rt & (id_rt == ex_q.rd)));
    end

    // A taken branch kills the ID instruction, so nothing upstream needs to freeze.
    assign stall = ~flush & (hold | load_use);

    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (flush) begin
            ex_d = '0;
        end else if (hold) begin
            ex_d = ex_q;
        end else if (load_use) begin
            // Bubble; the ID instruction is retried next cycle once the load has moved on.
            ex_d = '0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            ex_d = id_word;
            // An invalid slot carries its fields along but must not have side effects.
            if (!id_valid) begin
                ex_d.reg_write = 1'b0;
                ex_d.mem_read  = 1'b0;
                ex_d.mem_write = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_rs       = ex_q.rs;
    assign ex_rt       = ex_q.rt;
    assign ex_rd       = ex_q.rd;
    assign ex_rs_data  = ex_q.rs_data;
    assign ex_rt_data  = ex_q.rt_data;
    assign ex_imm      = ex_q.imm;
    assign ex_pc       = ex_q.pc;
    assign ex_RegWrite = ex_q.reg_write;
    assign ex_MemRead  = ex_q.mem_read;
    assign ex_MemWrite = ex_q.mem_write;
    assign ex_MemtoReg = ex_q.mem_to_reg;
    assign ex_ALUSrc   = ex_q.alu_src;
    assign ex_ALUOp    = ex_q.alu_op;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus random traffic against a reference model.
// Latency: outputs checked #1 after each rising edge, stall checked mid-cycle.
// Backpressure: hold/flush are randomized; the model applies the flush > hold > load-use > load order.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 10;  // narrow counter so saturation is reachable quickly
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [4:0]        id_rs, id_rt, id_rd;
    logic              id_uses_rs, id_uses_rt;
    logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm, id_pc;
    logic              id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_ALUSrc;
    logic [3:0]        id_ALUOp;
    logic              hold, flush;
    logic              ex_valid;
    logic [4:0]        ex_rs, ex_rt, ex_rd;
    logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc;
    logic              ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc;
    logic [3:0]        ex_ALUOp;
    logic              stall;
    logic [CNT_W-1:0]  stall_count;

    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc(id_pc),
        .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
        .id_MemtoReg(id_MemtoReg), .id_ALUSrc(id_ALUSrc), .id_ALUOp(id_ALUOp),
        .hold(hold), .flush(flush),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_MemtoReg(ex_MemtoReg), .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp),
        .stall(stall), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // One snapshot of everything visible on the EX side.
    typedef struct packed {
        logic              valid;
        logic [4:0]        rs, rt, rd;
        logic [DATA_W-1:0] rs_data, rt_data, imm, pc;
        logic              regwrite, memread, memwrite, memtoreg, alusrc;
        logic [3:0]        aluop;
    } ex_t;

    ex_t              m_ex;
    logic [CNT_W-1:0] m_cnt;
    int               n_checks = 0;
    int               n_errors = 0;

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic ex_t dut_ex();
        return '{ex_valid, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm, ex_pc,
                 ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_ALUSrc, ex_ALUOp};
    endfunction

    // Reference: does the instruction in ID need a value the load in EX has not produced yet?
    function automatic logic m_hazard();
        if (!(m_ex.valid && m_ex.memread && id_valid) || m_ex.rd == 5'd0) return 1'b0;
        return (id_uses_rs && id_rs == m_ex.rd) || (id_uses_rt && id_rt == m_ex.rd);
    endfunction

    function automatic logic m_stall();
        if (flush) return 1'b0;
        return hold || m_hazard();
    endfunction

    // Reference register update for one rising edge.
    task automatic m_edge();
        logic hz;
        hz = m_hazard();
        if (flush) begin
            m_ex = '0;
        end else if (hold) begin
            // unchanged
        end else if (hz) begin
            m_ex = '0;
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end else begin
            m_ex = '{id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_pc,
                     id_RegWrite && id_valid, id_MemRead && id_valid, id_MemWrite && id_valid,
                     id_MemtoReg, id_ALUSrc, id_ALUOp};
        end
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic step();
        #1;
        chk("stall", 192'(stall), 192'(m_stall()));
        @(posedge clk);
        m_edge();
        #1;
        chk("ex_regs", 192'(dut_ex()), 192'(m_ex));
        chk("stall_count", 192'(stall_count), 192'(m_cnt));
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic urs, input logic urt,
                          input logic mr, input logic rw);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_uses_rs = urs; id_uses_rt = urt;
        id_MemRead = mr; id_RegWrite = rw;
        id_MemWrite = 1'($urandom); id_MemtoReg = mr; id_ALUSrc = 1'($urandom);
        id_ALUOp = 4'($urandom);
        id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom; id_pc = $urandom;
    endtask

    task automatic idle_ctl();
        hold = 1'b0; flush = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ex_t snap;
        int  n;
        rst = 1'b1;
        idle_ctl();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        m_ex = '0; m_cnt = '0;

        // Reset state and stall behaviour while in reset.
        #12;
        chk("rst_ex", 192'(dut_ex()), 192'(0));
        chk("rst_cnt", 192'(stall_count), 192'(0));
        hold = 1'b1; #1;
        chk("rst_stall_hold", 192'(stall), 192'(1));
        flush = 1'b1; #1;
        chk("rst_stall_flush", 192'(stall), 192'(0));
        @(negedge clk);
        idle_ctl();
        rst = 1'b0;

        // Pass-through.
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        id_rs_data = 32'h1234;
        step();
        chk("pass_rd", 192'(ex_rd), 192'(5));
        chk("pass_rs_data", 192'(ex_rs_data), 192'(32'h1234));
        chk("pass_stall", 192'(stall), 192'(0));

        // Load-use: lw r8, then an instruction reading r8.
        set_id(1'b1, 5'd3, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        set_id(1'b1, 5'd8, 5'd4, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        chk("lu_stall", 192'(stall), 192'(1));
        step();
        chk("lu_bubble", 192'(ex_valid), 192'(0));
        chk("lu_count", 192'(stall_count), 192'(1));
        step();
        chk("lu_retry_rs", 192'(ex_rs), 192'(8));
        chk("lu_retry_valid", 192'(ex_valid), 192'(1));

        // Non-hazards: rs not used, load targets r0, producer is not a load.
        for (int k = 0; k < 3; k++) begin
            set_id(1'b1, 5'd3, 5'd0, (k == 1) ? 5'd0 : 5'd8, 1'b1, 1'b0, (k != 2), 1'b1);
            step();
            set_id(1'b1, (k == 1) ? 5'd0 : 5'd8, 5'd4, 5'd9, (k != 0), 1'b0, 1'b0, 1'b1);
            #1;
            chk("nohz_stall", 192'(stall), 192'(0));
            step();
            chk("nohz_valid", 192'(ex_valid), 192'(1));
            chk("nohz_count", 192'(stall_count), 192'(1));
        end

        // Flush beats hold and load-use.
        set_id(1'b1, 5'd3, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        set_id(1'b1, 5'd8, 5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
        hold = 1'b1; flush = 1'b1;
        #1;
        chk("flush_stall", 192'(stall), 192'(0));
        step();
        chk("flush_bubble", 192'(dut_ex()), 192'(0));
        chk("flush_count", 192'(stall_count), 192'(1));

        // Hold alone for three edges.
        idle_ctl();
        set_id(1'b1, 5'd6, 5'd7, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        snap = dut_ex();
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_id(1'b1, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b0, 1'b1);
            #1;
            chk("hold_stall", 192'(stall), 192'(1));
            step();
            chk("hold_keep", 192'(dut_ex()), 192'(snap));
        end

        // Hold with a pending hazard: no count, hazard taken once hold drops.
        idle_ctl();
        set_id(1'b1, 5'd3, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        set_id(1'b1, 5'd1, 5'd12, 5'd13, 1'b0, 1'b1, 1'b0, 1'b1);
        hold = 1'b1;
        step();
        step();
        chk("hold_hz_count", 192'(stall_count), 192'(1));
        hold = 1'b0;
        step();
        chk("hold_hz_after", 192'(stall_count), 192'(2));

        // Random traffic on a small register set so hazards are frequent.
        for (int k = 0; k < 600; k++) begin
            set_id(1'($urandom_range(0, 5) != 0), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom));
            hold  = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            step();
        end

        // Saturation: back-to-back dependent loads, lw r8, 0(r8).
        idle_ctl();
        set_id(1'b1, 5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
        n = 0;
        while (m_cnt != CNT_MAX - 1 && n < 4 * (1 << CNT_W)) begin
            step();
            n++;
        end
        chk("sat_reach", 192'(stall_count), 192'(CNT_MAX - 1));
        step(); step();
        chk("sat_max", 192'(stall_count), 192'(CNT_MAX));
        step(); step();
        chk("sat_hold", 192'(stall_count), 192'(CNT_MAX));

        // Mid-cycle asynchronous reset.
        #2;
        rst = 1'b1;
        #1;
        m_ex = '0; m_cnt = '0;
        chk("arst_ex", 192'(dut_ex()), 192'(0));
        chk("arst_cnt", 192'(stall_count), 192'(0));
        chk("arst_stall", 192'(stall), 192'(0));
        hold = 1'b1; #1;
        chk("arst_stall_hold", 192'(stall), 192'(1));
        @(negedge clk);
        idle_ctl();
        rst = 1'b0;
        set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        chk("post_rst_rd", 192'(ex_rd), 192'(7));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
